// File: rtl/instr_sequencer.sv
// Five-state instruction sequencer: fetch, execute, and hand results
// to a valid/ready consumer.
module instr_sequencer #(
  parameter int PC_LAST = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] addr,
  input  logic [15:0] instruction,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT,
    S_HALT
  } state_t;

  localparam logic [7:0] LAST = 8'(PC_LAST);

  localparam logic [5:0] OP_HALT  = 6'h00;
  localparam logic [5:0] OP_LOADA = 6'h01;
  localparam logic [5:0] OP_LOADB = 6'h02;
  localparam logic [5:0] OP_ADD   = 6'h03;
  localparam logic [5:0] OP_READ  = 6'h04;

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] acc;

  logic [5:0]  op;
  logic [15:0] operand;
  logic        is_halt;
  logic        is_loada;
  logic        is_loadb;
  logic        is_add;
  logic        is_read;

  logic        at_last;
  state_t      adv_state;
  logic [7:0]  adv_pc;

  assign op       = ir[15:10];
  assign operand  = {6'b0, ir[9:0]};
  assign is_halt  = (op == OP_HALT);
  assign is_loada = (op == OP_LOADA);
  assign is_loadb = (op == OP_LOADB);
  assign is_add   = (op == OP_ADD);
  assign is_read  = (op == OP_READ);

  // Shared "advance" outcome: halt after the last address, else step
  assign at_last   = (pc == LAST);
  assign adv_state = at_last ? S_HALT : S_FETCH;
  assign adv_pc    = at_last ? pc : pc + 8'd1;

  assign addr   = {8'b0, pc};
  assign busy   = (state == S_FETCH) ||
                  (state == S_EXEC) ||
                  (state == S_OUT);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= 8'd0;
      ir        <= 16'd0;
      a         <= 16'd0;
      b         <= 16'd0;
      acc       <= 16'd0;
      out_data  <= 16'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= 8'd0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= instruction;
          state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (1'b1)
            is_halt: begin
              state <= S_HALT;
            end
            is_loada: begin
              a     <= operand;
              pc    <= adv_pc;
              state <= adv_state;
            end
            is_loadb: begin
              b     <= operand;
              pc    <= adv_pc;
              state <= adv_state;
            end
            is_add: begin
              acc   <= a + b;
              pc    <= adv_pc;
              state <= adv_state;
            end
            is_read: begin
              out_data  <= acc;
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
            default: begin
              err   <= 1'b1;
              state <= S_HALT;
            end
          endcase
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= adv_pc;
            state     <= adv_state;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level program
// model predicts results, a monitor checks every presented output.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] addr, instruction, out_data;
  logic        out_valid, busy, halted, err;
  logic [15:0] addr3, instruction3, out_data3;
  logic        out_valid3, busy3, halted3, err3;

  logic [15:0] mem [256];

  assign instruction  = mem[addr[7:0]];
  assign instruction3 = mem[addr3[7:0]];

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr(addr), .instruction(instruction),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy),
    .halted(halted), .err(err)
  );

  instr_sequencer #(.PC_LAST(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr(addr3), .instruction(instruction3),
    .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .busy(busy3),
    .halted(halted3), .err(err3)
  );

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_cycles = 0;
  int   stall_cycles = 0;
  int   ready_mode = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Consumer: 0 always ready, 1 random, 2 stall 5 cycles, 3 never
  initial begin
    int scnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom % 3) != 0;
        2: begin
          if (out_valid && scnt < 5) begin
            out_ready = 1'b0;
            scnt++;
          end else begin
            out_ready = 1'b1;
            if (!out_valid) scnt = 0;
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare presented outputs with the scoreboard head
  initial begin
    bit hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_prev = 1'b0;
        continue;
      end
      if (hs_prev) check("valid_drop", {31'b0, out_valid}, 0);
      hs_prev = 1'b0;
      if (busy) busy_cycles++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_addr", addr, exp_q[0].pc);
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_prev = 1'b1;
          end else begin
            stall_cycles++;
          end
        end
      end
    end
  end

  // Instruction-level reference: walk the program, record outputs
  task automatic model(input int last, output int n_ins,
                       output int n_rd, output bit m_err,
                       output int m_pc);
    int          pc = 0;
    logic [15:0] a = 0, b = 0, acc = 0, w;
    int          opc;
    n_ins = 0;
    n_rd  = 0;
    m_err = 0;
    while (1) begin
      w   = mem[pc];
      opc = int'(w[15:10]);
      n_ins++;
      if (opc == 0) break;
      if (opc > 4) begin
        m_err = 1;
        break;
      end
      if (opc == 1) a = {6'b0, w[9:0]};
      if (opc == 2) b = {6'b0, w[9:0]};
      if (opc == 3) acc = a + b;
      if (opc == 4) begin
        exp_q.push_back('{data: acc, pc: 16'(pc)});
        n_rd++;
      end
      if (pc == last) break;
      pc++;
    end
    m_pc = pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic load(input logic [15:0] p[$]);
    foreach (mem[i]) mem[i] = 16'($urandom);
    foreach (p[i]) mem[i] = p[i];
  endtask

  task automatic run_prog(input int mode, input bit rand_start);
    int n_ins, n_rd, m_pc, cyc;
    bit m_err;
    ready_mode = mode;
    model(255, n_ins, n_rd, m_err, m_pc);
    @(negedge clk);
    busy_cycles  = 0;
    stall_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 4000) begin
      if (rand_start) start = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("halt_timeout", {31'b0, cyc < 4000}, 1);
    check("halted", {31'b0, halted}, 1);
    check("err", {31'b0, err}, {31'b0, m_err});
    check("final_addr", addr, m_pc);
    check("busy_end", {31'b0, busy}, 0);
    check("valid_end", {31'b0, out_valid}, 0);
    check("queue_empty", exp_q.size(), 0);
    check("latency", busy_cycles,
          2 * n_ins + n_rd + stall_cycles);
    exp_q.delete();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("halt_sticky", {31'b0, halted}, 1);
    check("halt_addr", addr, m_pc);
  endtask

  logic [15:0] prog34[$] = '{16'h042D, 16'h0836, 16'h0C00,
                            16'h1000, 16'h0000};

  initial begin
    int cyc, len, sel;
    logic [15:0] rp[$];

    do_reset();
    check("rst_addr", addr, 0);
    check("rst_data", out_data, 0);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_halted", {31'b0, halted}, 0);
    check("rst_err", {31'b0, err}, 0);

    load(prog34);
    run_prog(0, 0);
    check("p34_cycles", busy_cycles, 11);

    do_reset();
    run_prog(2, 0);
    check("p35_stalls", stall_cycles, 5);

    do_reset();
    load('{16'h07FF, 16'h0BFF, 16'h0C00, 16'h1000, 16'h0000});
    run_prog(0, 0);
    check("p36_data", out_data, 16'h07FE);

    do_reset();
    load('{16'h3C00});
    run_prog(0, 0);
    check("p37_cycles", busy_cycles, 2);

    do_reset();
    load('{16'h0407, 16'h0808, 16'h0C00, 16'h1000, 16'h0000});
    run_prog(0, 0);
    check("p38_halted", {31'b0, halted3}, 1);
    check("p38_addr", addr3, 16'h0003);
    check("p38_err", {31'b0, err3}, 0);
    check("p38_data", out_data3, 16'h000F);

    do_reset();
    load(prog34);
    ready_mode = 3;
    begin
      int n_ins, n_rd, m_pc;
      bit m_err;
      model(255, n_ins, n_rd, m_err, m_pc);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("p39_reach_out", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("p39_valid", {31'b0, out_valid}, 0);
    check("p39_busy", {31'b0, busy}, 0);
    check("p39_halted", {31'b0, halted}, 0);
    check("p39_addr", addr, 0);
    check("p39_data", out_data, 0);
    rst_n = 1'b1;
    exp_q.delete();
    run_prog(0, 0);

    for (int t = 0; t < 20; t++) begin
      do_reset();
      rp.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 19);
        if (sel < 5)
          rp.push_back({6'd1, 10'($urandom)});
        else if (sel < 10)
          rp.push_back({6'd2, 10'($urandom)});
        else if (sel < 14)
          rp.push_back({6'd3, 10'($urandom)});
        else if (sel < 19)
          rp.push_back({6'd4, 10'($urandom)});
        else
          rp.push_back({6'($urandom_range(5, 63)), 10'($urandom)});
      end
      rp.push_back({6'd0, 10'($urandom)});
      load(rp);
      run_prog(t % 3, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_LAST, default 255, meaning the highest valid instruction address; after the instruction at this address completes, the block halts.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  begins execution from address 0 when sampled high in IDLE.
REQ-005 SHALL have port addr  output  16  instruction address to the instruction memory; the upper 8 bits are always 0.
REQ-006 SHALL have port instruction  input  16  instruction word returned combinationally for addr; bits[15:10] are the opcode and bits[9:0] are the operand.
REQ-007 SHALL have port out_data  output  16  result presented by READOUT.
REQ-008 SHALL have port out_valid  output  1  out_data is valid; held until accepted.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data when high together with out_valid.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE and HALT.
REQ-011 SHALL have port halted  output  1  high in the HALT state.
REQ-012 SHALL have port err  output  1  sticky flag; set when an illegal opcode is executed.

Function
REQ-013 SHALL decode opcodes as follows: 0x00 HALT, 0x01 LOADA, 0x02 LOADB, 0x03 ADD, 0x04 READOUT; opcodes 0x05-0x3F are illegal.
REQ-014 SHALL implement five states: IDLE, FETCH, EXEC, OUT, HALT.
REQ-015 In IDLE: start=1 clears pc to 0 and moves to FETCH; start=0 stays in IDLE.
REQ-016 In FETCH: addr = pc; on the clock edge the IR register captures instruction, and the state moves to EXEC.
REQ-017 In EXEC, LOADA: A <= zero-extended operand; pc advances.
REQ-018 In EXEC, LOADB: B <= zero-extended operand; pc advances.
REQ-019 In EXEC, ADD: ACC <= (A + B) mod 2^16; operand bits are ignored; pc advances.
REQ-020 In EXEC, READOUT: out_data <= ACC; state moves to OUT.
REQ-021 In EXEC, HALT: state moves to HALT; pc is not advanced.
REQ-022 In EXEC, an illegal opcode sets err and moves to HALT.
REQ-023 "pc advances" means: if pc == PC_LAST, go to HALT; otherwise pc <= pc+1 and go to FETCH.
REQ-024 In OUT: out_valid = 1 and out_data is held stable; out_valid && out_ready then applies the advance rule of REQ-023 in the same edge.
REQ-025 In OUT, out_valid SHALL deassert in the cycle after the handshake.
REQ-026 In OUT, if out_ready is low, the block SHALL wait indefinitely with no timeout.
REQ-027 Latency: a non-READOUT instruction takes exactly 2 cycles (FETCH+EXEC); READOUT takes 3 cycles minimum (FETCH+EXEC+OUT), plus 1 per out_ready-low stall cycle.
REQ-028 In HALT: the state is held and start is ignored; only reset exits HALT.
REQ-029 start SHALL be ignored in every state other than IDLE.
REQ-030 addr SHALL equal {8'b0, pc} in all states.

Reset
REQ-031 When rst_n=0 at a clock edge, the following SHALL be forced: state=IDLE, pc=0, A=B=ACC=IR=0, out_data=0x0000, out_valid=0, busy=0, halted=0, err=0.
REQ-032 Reset mid-operation, including in OUT with out_valid high, SHALL abort immediately with no handshake completion, and out_valid SHALL be 0 after that edge.
REQ-033 Reset SHALL take priority over start and out_ready.

Verification
REQ-034 Memory {0x042D (LOADA 45), 0x0836 (LOADB 54), 0x0C00 (ADD), 0x1000 (READOUT), 0x0000 (HALT)}, start pulsed at edge 0, out_ready=1 -> out_valid rises after edge 8 with out_data=0x0063, then halted=1 after edge 11, err=0.
REQ-035 Same program with out_ready held low for 5 cycles after out_valid rises -> out_data stays 0x0063 and pc stays 3 throughout; the advance occurs on the first edge with out_ready=1.
REQ-036 LOADA 1023, LOADB 1023, ADD, READOUT -> out_data=0x07FE.
REQ-037 Memory word 0x3C00 (opcode 0x0F) at address 0 -> err=1 and halted=1 after edge 2; a later start has no effect.
REQ-038 PC_LAST=3 and a program with no HALT opcode -> after the address-3 instruction completes, halted=1 and addr stays 0x0003.
REQ-039 rst_n driven low during OUT -> after that edge out_valid=0, busy=0, state IDLE; a fresh start reruns the program from address 0 correctly.
